// File: rtl/abacus_pkg.sv
// Shared types and constants for the Abacus BCD conversion stage.
package abacus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    localparam int unsigned ITER        = 9;
    localparam int unsigned BCD_DIGITS  = 3;
    localparam int unsigned ADD3_THRESH = 5;
    localparam int unsigned CNT_W       = 4;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: adds 3 to a BCD digit of 5 or more before the next shift.
module bcd_add3
    import abacus_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    localparam logic [3:0] THRESH = 4'(ADD3_THRESH);

    always_comb begin
        dout = din;
        if (din >= THRESH) begin
            dout = din + 4'd3;
        end
    end

endmodule

// File: rtl/abacus_bcd_converter.sv
// Converts the signed Abacus adder/subtractor result into sign plus three BCD digits
// with a sequential shift-add-3 engine and a start/done handshake.
module abacus_bcd_converter
    import abacus_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [DATA_W-1:0] sum,
    input  logic [DATA_W-1:0] diff,
    input  logic              cout,
    output logic              busy,
    output logic              done,
    output logic              negative,
    output logic [3:0]        bcd_hundreds,
    output logic [3:0]        bcd_tens,
    output logic [3:0]        bcd_ones
);

    localparam int unsigned MAG_W = DATA_W + 1;
    localparam int unsigned BCD_W = 4 * BCD_DIGITS;

    state_e             state_q, state_d;
    logic [MAG_W-1:0]   mag_q, mag_d;
    logic [BCD_W-1:0]   scratch_q, scratch_d;
    logic [BCD_W-1:0]   scratch_adj;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sign_q, sign_d;
    logic               done_q, done_d;
    logic               negative_q, negative_d;
    logic [BCD_W-1:0]   digits_q, digits_d;

    logic [MAG_W-1:0]   mag_in;
    logic               sign_in;

    // A borrow in subtraction means diff holds a negative two's-complement value;
    // diff=0 with borrow is -256, which needs the full 9-bit magnitude.
    always_comb begin
        mag_in  = {cout, sum};
        sign_in = 1'b0;
        if (mode) begin
            if (cout) begin
                mag_in = {1'b0, diff};
            end else begin
                mag_in  = MAG_W'(1 << DATA_W) - {1'b0, diff};
                sign_in = 1'b1;
            end
        end
    end

    for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (scratch_q[4*i +: 4]),
            .dout (scratch_adj[4*i +: 4])
        );
    end

    always_comb begin
        state_d    = state_q;
        mag_d      = mag_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        sign_d     = sign_q;
        done_d     = 1'b0;
        negative_d = negative_q;
        digits_d   = digits_q;
        busy       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mag_d     = mag_in;
                    sign_d    = sign_in;
                    scratch_d = '0;
                    cnt_d     = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                busy               = 1'b1;
                {scratch_d, mag_d} = {scratch_adj[BCD_W-2:0], mag_q, 1'b0};
                cnt_d              = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(ITER - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                digits_d   = scratch_q;
                negative_d = sign_q;
                done_d     = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mag_q      <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            sign_q     <= 1'b0;
            done_q     <= 1'b0;
            negative_q <= 1'b0;
            digits_q   <= '0;
        end else begin
            state_q    <= state_d;
            mag_q      <= mag_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            sign_q     <= sign_d;
            done_q     <= done_d;
            negative_q <= negative_d;
            digits_q   <= digits_d;
        end
    end

    assign done         = done_q;
    assign negative     = negative_q;
    assign bcd_hundreds = digits_q[11:8];
    assign bcd_tens     = digits_q[7:4];
    assign bcd_ones     = digits_q[3:0];

endmodule

// File: tb/tb_abacus_bcd_converter.sv
// Scoreboard bench for abacus_bcd_converter: directed conversions, ignored starts, reset abort.
module tb_abacus_bcd_converter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       mode;
    logic [7:0] sum;
    logic [7:0] diff;
    logic       cout;
    logic       busy;
    logic       done;
    logic       negative;
    logic [3:0] bcd_hundreds;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;

    int checks = 0;
    int errors = 0;

    // {negative, hundreds, tens, ones}
    logic [12:0] exp_q[$];

    abacus_bcd_converter #(.DATA_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .mode         (mode),
        .sum          (sum),
        .diff         (diff),
        .cout         (cout),
        .busy         (busy),
        .done         (done),
        .negative     (negative),
        .bcd_hundreds (bcd_hundreds),
        .bcd_tens     (bcd_tens),
        .bcd_ones     (bcd_ones)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        logic [12:0] e;
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                e = exp_q.pop_front();
                check("negative", int'(negative), int'(e[12]));
                check("hundreds", int'(bcd_hundreds), int'(e[11:8]));
                check("tens", int'(bcd_tens), int'(e[7:4]));
                check("ones", int'(bcd_ones), int'(e[3:0]));
            end
        end
    end

    // Returns one negedge after the edge that samples start; inputs are then scrambled.
    task automatic issue(input logic m, input logic [7:0] s, input logic [7:0] d,
                         input logic c);
        @(negedge clk);
        mode  = m;
        sum   = s;
        diff  = d;
        cout  = c;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mode  = ~m;
        sum   = ~s;
        diff  = ~d;
        cout  = ~c;
    endtask

    task automatic convert(input string name, input logic m, input logic [7:0] s,
                           input logic [7:0] d, input logic c, input logic [12:0] e);
        int lat;
        int busy_cnt;
        exp_q.push_back(e);
        issue(m, s, d, c);
        lat      = 1;
        busy_cnt = busy ? 1 : 0;
        while (!done && lat < 30) begin
            @(negedge clk);
            lat++;
            if (!done && busy) busy_cnt++;
        end
        check({name, "_latency"}, lat, 11);
        check({name, "_busy_cycles"}, busy_cnt, 10);
        check({name, "_busy_after"}, int'(busy), 0);
    endtask

    initial begin
        int done_cnt;
        rst_n = 1'b0;
        start = 1'b0;
        mode  = 1'b0;
        sum   = 8'h00;
        diff  = 8'h00;
        cout  = 1'b0;
        #1;
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_digits", int'({negative, bcd_hundreds, bcd_tens, bcd_ones}), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        convert("add_510", 1'b0, 8'hFE, 8'h00, 1'b1, {1'b0, 4'd5, 4'd1, 4'd0});
        convert("sub_145", 1'b1, 8'h00, 8'h91, 1'b1, {1'b0, 4'd1, 4'd4, 4'd5});
        convert("sub_m145", 1'b1, 8'h00, 8'h6F, 1'b0, {1'b1, 4'd1, 4'd4, 4'd5});
        convert("sub_zero", 1'b1, 8'h00, 8'h00, 1'b1, {1'b0, 4'd0, 4'd0, 4'd0});
        convert("sub_m256", 1'b1, 8'h00, 8'h00, 1'b0, {1'b1, 4'd2, 4'd5, 4'd6});

        // Hold between conversions
        repeat (4) @(negedge clk);
        check("hold_digits", int'({negative, bcd_hundreds, bcd_tens, bcd_ones}),
              int'({1'b1, 4'd2, 4'd5, 4'd6}));

        // Reset mid-conversion aborts with no done pulse
        issue(1'b0, 8'h2A, 8'h00, 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_digits", int'({negative, bcd_hundreds, bcd_tens, bcd_ones}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        convert("after_abort_42", 1'b0, 8'h2A, 8'h00, 1'b0, {1'b0, 4'd0, 4'd4, 4'd2});

        // Starts at relative edges 3 (busy) and 10 (DONE) must be ignored
        exp_q.push_back({1'b0, 4'd1, 4'd2, 4'd0});
        issue(1'b0, 8'h78, 8'h00, 1'b0);
        done_cnt = 0;
        for (int k = 2; k <= 26; k++) begin
            @(negedge clk);
            if (done) done_cnt++;
            start = 1'b0;
            if (k == 3 || k == 10) begin
                start = 1'b1;
                mode  = 1'b1;
                sum   = 8'h33;
                diff  = 8'h01;
                cout  = 1'b1;
            end
            if (k == 11) begin
                check("ignore_done_at_11", int'(done), 1);
                check("ignore_busy_at_11", int'(busy), 0);
            end
        end
        check("ignore_done_count", done_cnt, 1);
        check("ignore_digits_hold", int'({negative, bcd_hundreds, bcd_tens, bcd_ones}),
              int'({1'b0, 4'd1, 4'd2, 4'd0}));

        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
